// File: rtl/edgefilter_pkg.sv
// Shared definitions for the Sobel edge filter: output mode encodings and
// the frame-tracking FSM state type.
package edgefilter_pkg;

  localparam logic [1:0] MODE_MAG = 2'd0;  // |gx| + |gy|
  localparam logic [1:0] MODE_GX  = 2'd1;  // |gx|
  localparam logic [1:0] MODE_GY  = 2'd2;  // |gy|
  localparam logic [1:0] MODE_THR = 2'd3;  // binary threshold of |gx| + |gy|

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/sobel_stream_filter_kernel.sv
// sobel_kernel: combinational 3x3 Sobel gradient, magnitude select and
// saturation.
//   win    : 9 pixels packed p0 (LSBs) .. p8, row-major, p0 = top-left
//   mode   : output select (MODE_* encodings)
//   thresh : threshold for MODE_THR
//   pix    : filtered pixel
module sobel_kernel
  import edgefilter_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [9*PIX_W-1:0] win,
  input  logic [1:0]         mode,
  input  logic [PIX_W-1:0]   thresh,
  output logic [PIX_W-1:0]   pix
);

  localparam int GW = PIX_W + 4;  // signed gradient width
  localparam int MW = PIX_W + 3;  // unsigned magnitude width

  logic signed [GW-1:0] p [9];
  logic signed [GW-1:0] gx, gy;
  logic [MW-1:0] ax, ay, sum, sel;

  always_comb begin
    for (int unsigned i = 0; i < 9; i++) begin
      p[i] = $signed({4'b0000, win[i*PIX_W +: PIX_W]});
    end
    gx = (p[2] + (p[5] <<< 1) + p[8]) - (p[0] + (p[3] <<< 1) + p[6]);
    gy = (p[0] + (p[1] <<< 1) + p[2]) - (p[6] + (p[7] <<< 1) + p[8]);
    ax = gx[GW-1] ? MW'(-gx) : MW'(gx);
    ay = gy[GW-1] ? MW'(-gy) : MW'(gy);
    sum = ax + ay;

    case (mode)
      MODE_GX: sel = ax;
      MODE_GY: sel = ay;
      default: sel = sum;
    endcase

    if (mode == MODE_THR) begin
      // Compare uses the full-width sum, not the saturated value.
      pix = (sum >= MW'(thresh)) ? '1 : '0;
    end else if (|sel[MW-1:PIX_W]) begin
      pix = '1;
    end else begin
      pix = sel[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: streaming 3x3 Sobel filter over raster-order frames.
// Outputs only interior pixels ((IMG_W-2)*(IMG_H-2) per frame).
//   clk, rst_n                 : clock, async active-low reset
//   s_valid/s_ready/s_data/s_sof : input pixel stream, s_sof marks pixel (0,0)
//   mode, thresh               : output select / threshold, sampled at s_sof
//   m_valid/m_ready/m_data     : output pixel stream
//   m_sof/m_eol/m_eof          : first pixel / line end / frame end markers
module sobel_stream_filter
  import edgefilter_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t           state;
  logic [RW-1:0]    row;       // row of the next expected pixel
  logic [CW-1:0]    col;       // column of the next expected pixel
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] thresh_q;

  logic [PIX_W-1:0] lb0 [IMG_W];  // line r-2
  logic [PIX_W-1:0] lb1 [IMG_W];  // line r-1
  logic [PIX_W-1:0] w   [9];      // current window
  logic [PIX_W-1:0] w_n [9];      // window including the incoming pixel

  logic [9*PIX_W-1:0] win_flat;
  logic [PIX_W-1:0]   k_pix;
  logic               accept, take, emit, last_c, last_r;
  logic [RW-1:0]      cur_r;
  logic [CW-1:0]      cur_c;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  // A sof beat is always pixel (0,0), whatever the current position.
  assign take    = accept && (s_sof || state == ACTIVE);
  assign cur_r   = s_sof ? '0 : row;
  assign cur_c   = s_sof ? '0 : col;
  assign last_c  = cur_c == CW'(IMG_W - 1);
  assign last_r  = cur_r == RW'(IMG_H - 1);
  // Window is complete once the bottom-right pixel at (>=2, >=2) arrives;
  // the first two lines of each frame are always refilled before use.
  assign emit    = take && (cur_r >= RW'(2)) && (cur_c >= CW'(2));

  // Kernel sees the window after the incoming pixel is shifted in, so the
  // result registers on the same edge that accepts the pixel.
  always_comb begin
    w_n[0] = w[1]; w_n[1] = w[2]; w_n[2] = lb0[cur_c];
    w_n[3] = w[4]; w_n[4] = w[5]; w_n[5] = lb1[cur_c];
    w_n[6] = w[7]; w_n[7] = w[8]; w_n[8] = s_data;
    win_flat = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      win_flat[i*PIX_W +: PIX_W] = w_n[i];
    end
  end

  sobel_kernel #(.PIX_W(PIX_W)) u_kernel (
    .win    (win_flat),
    .mode   (mode_q),
    .thresh (thresh_q),
    .pix    (k_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_sof    <= 1'b0;
      m_eol    <= 1'b0;
      m_eof    <= 1'b0;
    end else begin
      if (take) begin
        if (s_sof) begin
          mode_q   <= mode;
          thresh_q <= thresh;
        end
        if (last_c) begin
          col <= '0;
          row <= last_r ? '0 : cur_r + RW'(1);
        end else begin
          col <= cur_c + CW'(1);
          row <= cur_r;
        end
        state <= (last_c && last_r) ? IDLE : ACTIVE;
      end

      if (emit) begin
        m_valid <= 1'b1;
        m_data  <= k_pix;
        m_sof   <= (cur_r == RW'(2)) && (cur_c == CW'(2));
        m_eol   <= last_c;
        m_eof   <= last_c && last_r;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      lb0[cur_c] <= lb1[cur_c];
      lb1[cur_c] <= s_data;
      for (int unsigned i = 0; i < 9; i++) begin
        w[i] <= w_n[i];
      end
    end
  end

endmodule

// File: doc/sobel_stream_filter.md
SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

Interface
REQ-001 Parameter IMG_W, default 8: pixels per line; legal range 3 and up.
REQ-002 Parameter IMG_H, default 8: lines per frame; legal range 3 and up.
REQ-003 Parameter PIX_W, default 8: bits per pixel, unsigned.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  input pixel valid.
REQ-007 s_ready  output  1  block accepts the input pixel.
REQ-008 s_data  input  PIX_W  input pixel, raster order.
REQ-009 s_sof  input  1  qualifies s_data as pixel (0,0) of a frame.
REQ-010 mode  input  2  0 = |gx|+|gy|, 1 = |gx|, 2 = |gy|, 3 = threshold of |gx|+|gy|.
REQ-011 thresh  input  PIX_W  threshold for mode 3.
REQ-012 m_valid  output  1  output pixel valid.
REQ-013 m_ready  input  1  downstream accepts the output pixel.
REQ-014 m_data  output  PIX_W  filtered pixel.
REQ-015 m_sof / m_eol / m_eof  output  1 each  first output pixel of the frame / last pixel of an output line / last pixel of the frame.

Function
REQ-016 A beat is accepted when s_valid and s_ready are both high; s_ready SHALL equal (!m_valid || m_ready).
REQ-017 FSM SHALL have two states: IDLE and ACTIVE. IDLE goes to ACTIVE on an accepted s_sof beat, which is pixel (0,0). ACTIVE goes to IDLE on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-018 In IDLE, accepted beats without s_sof SHALL be discarded with no output.
REQ-019 In ACTIVE, an accepted s_sof beat SHALL restart the frame: counters go to (0,0), window history is ignored, and no output is produced from the prior partial frame.
REQ-020 mode and thresh SHALL be sampled on the accepted s_sof beat and held for the rest of the frame.
REQ-021 Line storage SHALL be two lines of IMG_W pixels plus a 3x3 window. Window p0..p8 is row-major and p0 is top-left (oldest line).
REQ-022 gx = (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6), and gy = (p0 + 2*p1 + p2) - (p6 + 2*p7 + p8). Both are signed and PIX_W+4 bits wide, so no overflow is possible.
REQ-023 The selected magnitude (unsigned, PIX_W+3 bits) SHALL saturate to 2^PIX_W-1.
REQ-024 Mode 3 output is all-ones when |gx|+|gy| >= thresh (unsaturated compare), else 0.
REQ-025 Output is produced only for full windows, i.e. centres (r,c) with 1<=r<=IMG_H-2 and 1<=c<=IMG_W-2. That gives (IMG_W-2)*(IMG_H-2) pixels per frame in raster order; no border pixels are output.
REQ-026 Latency: m_valid SHALL rise on the clock edge that accepts pixel (r+1, c+1), so it is visible the cycle after that handshake.
REQ-027 While m_valid && !m_ready, m_data and all m_* flags SHALL hold stable.
REQ-028 m_sof is asserted with centre (1,1). m_eol is asserted with c = IMG_W-2. m_eof is asserted with centre (IMG_H-2, IMG_W-2).
REQ-029 The first output of a new frame SHALL NOT use pixels from the previous frame.
REQ-030 A sustained rate of 1 pixel/cycle SHALL be achieved when m_ready is held high.

Reset
REQ-031 While rst_n is low: state = IDLE, counters = 0, m_valid = 0, m_data = 0, all m_* flags = 0, sampled mode/thresh = 0.
REQ-032 Line-buffer and window contents need not be reset.
REQ-033 A reset mid-frame SHALL abort the frame with no further outputs from it; s_ready is 1 on the first cycle after release.

Structure
REQ-034 Shared package edgefilter_pkg SHALL hold the mode encoding constants (MODE_MAG, MODE_GX, MODE_GY, MODE_THR) and the FSM state type.
REQ-035 The combinational gradient, magnitude and saturation logic SHALL be one sub-module, sobel_kernel, parameterised by PIX_W. The filter owns the FSM, counters, line buffers and output register.

Verification (IMG_W=4, IMG_H=4, PIX_W=8)
REQ-036 Flat frame of all 100, mode 0 -> 4 outputs, all 0; m_sof on output 1, m_eol on outputs 2 and 4, m_eof on output 4.
REQ-037 Columns 0-1 = 0 and columns 2-3 = 10: mode 0 -> 40,40,40,40; mode 2 -> 0,0,0,0.
REQ-038 Same step at 255, mode 1 -> 255 x4 (saturated from 1020).
REQ-039 Step of 10, mode 3: thresh 41 -> 0 x4; thresh 40 -> 255 x4.
REQ-040 m_ready held low for 5 cycles while m_valid is high -> m_data stable, s_ready low, exactly 4 outputs with no loss or duplication.
REQ-041 Either of two disruptions followed by a full frame -> exactly 4 outputs, matching a clean frame:
- rst_n pulsed after 7 pixels;
- s_sof re-asserted at pixel 7.
